// File: rtl/mig_write_issuer_if.sv
// mig_write_issuer_if
//   Bundles the two upstream valid/ready streams (address, data + last),
//   the MIG UI write-side signals and the frame/statistics outputs of
//   mig_write_issuer.
//   Parameters: ADDR_W (address width), DATA_W (data width, mask is DATA_W/8).
//   Modports:
//     slave  - the write issuer itself (consumes streams, drives MIG)
//     master - the environment (produces streams, models the MIG)
interface mig_write_issuer_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);
  logic                  addr_valid_in;
  logic                  addr_ready_out;
  logic [ADDR_W-1:0]     addr_in;
  logic                  data_valid_in;
  logic                  data_ready_out;
  logic [DATA_W-1:0]     data_in;
  logic                  last_in;
  logic                  app_rdy_in;
  logic                  app_wdf_rdy_in;
  logic                  app_en_out;
  logic [2:0]            app_cmd_out;
  logic [ADDR_W-1:0]     app_addr_out;
  logic [DATA_W-1:0]     app_wdf_data_out;
  logic                  app_wdf_wren_out;
  logic                  app_wdf_end_out;
  logic [DATA_W/8-1:0]   app_wdf_mask_out;
  logic                  frame_done_out;
  logic [31:0]           beat_count_out;
  logic [31:0]           stall_count_out;

  modport slave (
    input  addr_valid_in, addr_in, data_valid_in, data_in, last_in,
           app_rdy_in, app_wdf_rdy_in,
    output addr_ready_out, data_ready_out, app_en_out, app_cmd_out,
           app_addr_out, app_wdf_data_out, app_wdf_wren_out,
           app_wdf_end_out, app_wdf_mask_out, frame_done_out,
           beat_count_out, stall_count_out
  );

  modport master (
    output addr_valid_in, addr_in, data_valid_in, data_in, last_in,
           app_rdy_in, app_wdf_rdy_in,
    input  addr_ready_out, data_ready_out, app_en_out, app_cmd_out,
           app_addr_out, app_wdf_data_out, app_wdf_wren_out,
           app_wdf_end_out, app_wdf_mask_out, frame_done_out,
           beat_count_out, stall_count_out
  );
endinterface

// File: rtl/mig_write_issuer.sv
// mig_write_issuer
//   Joins an address beat and a data beat (popped together from two
//   valid/ready streams) into a single-entry holding register and issues it
//   to the MIG UI as one write: command on app_en/app_rdy and data on
//   app_wdf_wren/app_wdf_rdy, the two handshakes completing independently.
//   frame_done_out pulses the cycle after a beat tagged last has retired.
//   Ports:
//     clk_in  - single clock, rising edge
//     rst_in  - synchronous active-high reset
//     bus     - mig_write_issuer_if.slave (streams, MIG UI, frame/stats)
//   Parameters: ADDR_W, DATA_W, ADDR_SHIFT (address left shift, truncated).
//   Optional: define MIG_WRITE_ISSUER_STATS_EN to build the beat and stall
//   counters; otherwise both counter outputs are tied to 0.
module mig_write_issuer #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 128,
  parameter int ADDR_SHIFT = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mig_write_issuer_if.slave     bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               last_q;
  logic               cmd_done_q;
  logic               data_done_q;
  logic               frame_done_q;

  logic [ADDR_W-1:0]  shifted_addr;
  logic               app_en;
  logic               wdf_wren;
  logic               cmd_fire;
  logic               data_fire;
  logic               retire;
  logic               accept;

  // Shift is evaluated in ADDR_W context, so high bits fall off silently.
  assign shifted_addr = bus.addr_in << ADDR_SHIFT;

  // Handshake decode and next state. Outputs are gated with rst_in so no
  // MIG handshake or upstream pop can complete in a reset cycle. retire
  // means every handshake still owed completes now; it frees the slot for
  // a same-cycle reload, which gives one pair per cycle with no bubble.
  always_comb begin
    state_d   = state_q;
    app_en    = 1'b0;
    wdf_wren  = 1'b0;
    cmd_fire  = 1'b0;
    data_fire = 1'b0;
    retire    = 1'b0;
    accept    = 1'b0;
    if (!rst_in && state_q == ISSUE) begin
      app_en   = !cmd_done_q;
      wdf_wren = !data_done_q;
    end
    cmd_fire  = app_en && bus.app_rdy_in;
    data_fire = wdf_wren && bus.app_wdf_rdy_in;
    retire    = !rst_in && (state_q == ISSUE) &&
                (cmd_done_q || cmd_fire) && (data_done_q || data_fire);
    accept    = !rst_in && bus.addr_valid_in && bus.data_valid_in &&
                ((state_q == IDLE) || retire);
    if (accept) begin
      state_d = ISSUE;
    end else if (retire) begin
      state_d = IDLE;
    end
  end

  // Holding register and per-handshake completion flags. The register only
  // changes on accept, so address/data stay stable while their valid is up.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      cmd_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= retire && last_q;
      if (accept) begin
        addr_q <= shifted_addr;
        data_q <= bus.data_in;
        last_q <= bus.last_in;
      end
      if (accept || retire) begin
        cmd_done_q  <= 1'b0;
        data_done_q <= 1'b0;
      end else begin
        if (cmd_fire) begin
          cmd_done_q <= 1'b1;
        end
        if (data_fire) begin
          data_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.addr_ready_out   = accept;
  assign bus.data_ready_out   = accept;
  assign bus.app_en_out       = app_en;
  assign bus.app_cmd_out      = 3'b000;
  assign bus.app_addr_out     = addr_q;
  assign bus.app_wdf_data_out = data_q;
  assign bus.app_wdf_wren_out = wdf_wren;
  assign bus.app_wdf_end_out  = wdf_wren;
  assign bus.app_wdf_mask_out = '0;
  assign bus.frame_done_out   = frame_done_q;

`ifdef MIG_WRITE_ISSUER_STATS_EN
  logic [31:0] beat_count_q;
  logic [31:0] stall_count_q;

  // Beat counter restarts at each frame boundary; stall counter counts
  // ISSUE cycles that did not retire and sticks at all-ones.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (retire) begin
        beat_count_q <= last_q ? 32'd0 : beat_count_q + 32'd1;
      end
      if (state_q == ISSUE && !retire && stall_count_q != 32'hFFFF_FFFF) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign bus.beat_count_out  = beat_count_q;
  assign bus.stall_count_out = stall_count_q;
`else
  assign bus.beat_count_out  = 32'd0;
  assign bus.stall_count_out = 32'd0;
`endif

endmodule

// File: tb/tb_mig_write_issuer.sv
// tb_mig_write_issuer
//   Directed scenarios followed by randomized traffic for mig_write_issuer.
//   A transaction-level reference model (slot occupancy, owed handshakes,
//   expected address arithmetic, in-order scoreboards) predicts every output.
module tb_mig_write_issuer;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int SHIFT  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mig_write_issuer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mig_write_issuer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_SHIFT(SHIFT)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one write slot and which MIG handshakes it still owes.
  bit                 m_full;
  bit                 m_cmd_owed;
  bit                 m_data_owed;
  bit                 m_last;
  bit                 m_frame;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_data;
  longint             m_beats;
  longint             m_stalls;
  logic [ADDR_W-1:0]  cmd_q[$];
  logic [DATA_W-1:0]  wdf_q[$];

  // Block address scaled by 2^SHIFT, wrapped modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] scaled(input logic [ADDR_W-1:0] a);
    longint v;
    v = longint'(a) * (longint'(1) << SHIFT);
    return ADDR_W'(v % (longint'(1) << ADDR_W));
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_full = 0; m_cmd_owed = 0; m_data_owed = 0; m_last = 0; m_frame = 0;
    m_addr = '0; m_data = '0; m_beats = 0; m_stalls = 0;
    cmd_q.delete();
    wdf_q.delete();
  endtask

  // Compare every output against the model, then advance the model to the
  // state it must hold after the coming clock edge.
  task automatic evaluateCycle();
    bit en_e, wren_e, cmd_fire, data_fire, retiring, ready_e;
    logic [31:0] beats_e, stalls_e;
    en_e      = !rst && m_full && m_cmd_owed;
    wren_e    = !rst && m_full && m_data_owed;
    cmd_fire  = en_e && bus.app_rdy_in;
    data_fire = wren_e && bus.app_wdf_rdy_in;
    retiring  = !rst && m_full && (!m_cmd_owed || cmd_fire) && (!m_data_owed || data_fire);
    ready_e   = !rst && bus.addr_valid_in && bus.data_valid_in && (!m_full || retiring);
`ifdef MIG_WRITE_ISSUER_STATS_EN
    beats_e  = 32'(m_beats);
    stalls_e = 32'(m_stalls);
`else
    beats_e  = 32'd0;
    stalls_e = 32'd0;
`endif
    checkOutput("addr_ready", bus.addr_ready_out, ready_e);
    checkOutput("data_ready", bus.data_ready_out, ready_e);
    checkOutput("app_en", bus.app_en_out, en_e);
    checkOutput("app_wdf_wren", bus.app_wdf_wren_out, wren_e);
    checkOutput("app_wdf_end", bus.app_wdf_end_out, wren_e);
    checkOutput("app_cmd", bus.app_cmd_out, 3'b000);
    checkOutput("app_wdf_mask", bus.app_wdf_mask_out, '0);
    checkOutput("app_addr", bus.app_addr_out, m_addr);
    checkOutput("app_wdf_data", bus.app_wdf_data_out, m_data);
    checkOutput("frame_done", bus.frame_done_out, m_frame);
    checkOutput("beat_count", bus.beat_count_out, beats_e);
    checkOutput("stall_count", bus.stall_count_out, stalls_e);

    // In-order scoreboards: every MIG handshake must carry the oldest pair.
    if (bus.app_en_out && bus.app_rdy_in) begin
      checkOutput("cmd_sb_nonempty", (cmd_q.size() != 0), 1'b1);
      if (cmd_q.size() != 0) checkOutput("cmd_sb_order", bus.app_addr_out, cmd_q.pop_front());
    end
    if (bus.app_wdf_wren_out && bus.app_wdf_rdy_in) begin
      checkOutput("wdf_sb_nonempty", (wdf_q.size() != 0), 1'b1);
      if (wdf_q.size() != 0) checkOutput("wdf_sb_order", bus.app_wdf_data_out, wdf_q.pop_front());
    end

    if (rst) begin
      modelReset();
    end else begin
      m_frame = retiring && m_last;
      if (retiring) m_beats = m_last ? 0 : m_beats + 1;
      if (m_full && !retiring && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (cmd_fire)  m_cmd_owed  = 0;
      if (data_fire) m_data_owed = 0;
      if (ready_e) begin
        m_full = 1; m_cmd_owed = 1; m_data_owed = 1;
        m_addr = scaled(bus.addr_in);
        m_data = bus.data_in;
        m_last = bus.last_in;
        cmd_q.push_back(scaled(bus.addr_in));
        wdf_q.push_back(bus.data_in);
      end else if (retiring) begin
        m_full = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit av, input bit dv,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input bit l, input bit cr, input bit wr);
    rst = r;
    bus.addr_valid_in  = av;
    bus.data_valid_in  = dv;
    bus.addr_in        = a;
    bus.data_in        = d;
    bus.last_in        = l;
    bus.app_rdy_in     = cr;
    bus.app_wdf_rdy_in = wr;
    @(negedge clk);
    evaluateCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.addr_valid_in = 0; bus.data_valid_in = 0; bus.addr_in = '0;
    bus.data_in = '0; bus.last_in = 0; bus.app_rdy_in = 0; bus.app_wdf_rdy_in = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    $display("[TB] reset values");
    applyStimulus(1, 0, 0, '0, '0, 0, 1, 1);

    $display("[TB] back-to-back issue");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, ADDR_W'(i), 128'hA0 + i, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);

    $display("[TB] command before data");
    applyStimulus(0, 1, 1, 27'd10, 128'hB0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 27'd11, 128'hB1, 0, 1, 0);
    applyStimulus(0, 1, 1, 27'd11, 128'hB1, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);

    $display("[TB] data before command");
    applyStimulus(0, 1, 1, 27'd20, 128'hC0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, '0, '0, 0, 0, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);

    $display("[TB] unpaired beats");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 27'd5, 128'h55, 0, 1, 1);
    for (int i = 0; i < 4; i++)  applyStimulus(0, 0, 1, 27'd6, 128'h66, 0, 1, 1);

    $display("[TB] frame end");
    applyStimulus(0, 1, 1, 27'd159, 128'hF159, 1, 1, 1);
    checkOutput("frame_end_addr", bus.app_addr_out, 27'd2544);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 1, 1, 27'd30, 128'hD0, 1, 1, 0);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 0);
    applyStimulus(1, 1, 1, 27'd31, 128'hD1, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 79) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0,
                    ADDR_W'($urandom),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 7);
    end
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mig_write_issuer.md
# mig_write_issuer

Downstream of the frame test stacker in the DDR write path. Joins each 27-bit address beat with its 128-bit data beat, taken from two valid/ready streams. Issues each pair as one MIG UI write: command on `app_en`/`app_rdy`, data on `app_wdf_wren`/`app_wdf_rdy`, with the two MIG handshakes completing independently. Flags frame completion when the beat tagged `last` has fully retired.

## Interface
- `ADDR_W`, default 27: address width, upstream and MIG.
- `DATA_W`, default 128: data width; mask width is `DATA_W/8`.
- `ADDR_SHIFT`, default 0: left shift applied to `addr_in` before issue; result truncated to `ADDR_W`.

Ports:
- `clk_in`  in  1  single clock; all logic on its rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `addr_valid_in`  in  1  address beat valid.
- `addr_ready_out`  out  1  address beat accepted when this and `addr_valid_in` are both high.
- `addr_in`  in  `ADDR_W`  address in 128-bit block units.
- `data_valid_in`  in  1  data beat valid.
- `data_ready_out`  out  1  data beat accepted; always equal to `addr_ready_out`.
- `data_in`  in  `DATA_W`  write data.
- `last_in`  in  1  qualifies the current pair as the frame's final beat; sampled with the pair.
- `app_rdy_in`  in  1  MIG command ready.
- `app_wdf_rdy_in`  in  1  MIG write-data ready.
- `app_en_out`  out  1  command valid.
- `app_cmd_out`  out  3  constant `3'b000` (write).
- `app_addr_out`  out  `ADDR_W`  held address.
- `app_wdf_data_out`  out  `DATA_W`  held data.
- `app_wdf_wren_out`  out  1  data valid.
- `app_wdf_end_out`  out  1  equal to `app_wdf_wren_out` (single-beat bursts).
- `app_wdf_mask_out`  out  `DATA_W/8`  constant 0 (all bytes written).
- `frame_done_out`  out  1  one-cycle pulse after the last beat retires.
- `beat_count_out`  out  32  see Configuration.
- `stall_count_out`  out  32  see Configuration.

## Operation
- The block holds one entry: a register for `{addr, data, last}` plus flags `cmd_done` and `data_done`.
- State machine:
  - IDLE: holding register empty.
  - ISSUE: holding register full.
- `app_en_out = ISSUE && !cmd_done`.
- `app_wdf_wren_out = ISSUE && !data_done`.
- `cmd_done` sets on `app_en_out && app_rdy_in`.
- `data_done` sets on `app_wdf_wren_out && app_wdf_rdy_in`.
- Either MIG handshake may complete first, or both may complete in the same cycle.
- `retire` is true in ISSUE when every still-outstanding handshake completes this cycle.
- `ready_out = addr_valid_in && data_valid_in && (IDLE || retire)`.
  - Pairs are only ever popped jointly; a lone valid beat is never consumed.
  - Ready depends on valid; valid never depends on ready.
- On accept: load the holding register, clear both flags, go to (or stay in) ISSUE.
- On `retire` with no accept: go to IDLE.
- `frame_done_out` pulses in the cycle after a `retire` whose held `last` is 1.
- Address: `(addr_in << ADDR_SHIFT)`, truncated to `ADDR_W` bits; no overflow detection.

## Timing
- Reset values:
  - All `*_ready_out`, `app_en_out`, `app_wdf_wren_out`, `app_wdf_end_out` and `frame_done_out` are 0.
  - `app_addr_out` and `app_wdf_data_out` are 0.
  - Both counters are 0; state is IDLE; both flags are cleared.
- Reset mid-operation discards the held beat; no MIG handshake completes in the reset cycle.
- Latency: a pair accepted at edge N drives `app_en_out`/`app_wdf_wren_out` high in cycle N+1.
- Throughput:
  - One pair per cycle while `app_rdy_in` and `app_wdf_rdy_in` both stay high, by reload on `retire`.
  - The next beat appears on the MIG outputs with no bubble.
- `app_addr_out` and `app_wdf_data_out` stay stable while their respective valid is high.

## Configuration
- `MIG_WRITE_ISSUER_STATS_EN` defined:
  - `beat_count_out` increments on each `retire` and clears to 0 on the `retire` of a `last` beat.
  - `stall_count_out` increments each ISSUE cycle without `retire` and saturates at `32'hFFFF_FFFF`.
  - Both reset to 0.
- Undefined: both outputs tied to 0 and no counter logic is instantiated.

## Test plan
- Back-to-back issue:
  - Stimulus: both ready inputs held high; 4 pairs with addresses 0..3 and data `128'hA0..A3`, presented continuously.
  - Response: `app_en_out` high for 4 consecutive cycles with addresses 0,1,2,3 matching the data; `ready_out` high for 4 consecutive cycles.
- Command before data:
  - Stimulus: `app_rdy_in`=1, `app_wdf_rdy_in`=0 for 3 cycles, then 1.
  - Response: `app_en_out` pulses exactly 1 cycle; `app_wdf_wren_out` stays high 4 cycles; next pair is accepted on the retire cycle.
- Data before command:
  - Stimulus: `app_wdf_rdy_in`=1, `app_rdy_in`=0 for 5 cycles.
  - Response: one data handshake only; `app_wdf_wren_out` is 0 after it; `app_en_out` is held until `app_rdy_in` rises.
- Unpaired beat:
  - Stimulus: `addr_valid_in`=1, `data_valid_in`=0 for 10 cycles.
  - Response: both ready outputs stay 0; no MIG activity.
- Frame end:
  - Stimulus: beat 159 with `last_in`=1 and `ADDR_SHIFT`=4, address 159.
  - Response: `app_addr_out`=2544; `frame_done_out` pulses one cycle after retire; with the stats macro, `beat_count_out` returns to 0.
- Reset mid-operation:
  - Stimulus: assert `rst_in` while in ISSUE with `cmd_done`=1.
  - Response: the next cycle shows all outputs at reset values; the held beat is never written.
